// File: rtl/dtmf_tone_gen.sv
// dtmf_tone_gen
//   DTMF tone generator. A keypad digit is accepted with its tone and gap
//   lengths (in 8 kHz samples). Two 24-bit phase accumulators (row and
//   column) index a quarter-wave sine table; the sum of both sines is
//   presented left-justified on pdout_l/pdout_r. Each pdout_ack consumes
//   the presented sample. The tone is followed by a silent gap.
//
//   Optional feature: define DTMF_TONE_GEN_ABORT_EN to add the abort input.
//
// Ports
//   mclk         in   12.288 MHz clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   digit_valid  in   digit request
//   digit_ready  out  high only while idle
//   digit        in   0-9, 10='*', 11='#', 12-15='A'-'D'
//   tone_samples in   tone length in samples, latched at accept
//   gap_samples  in   silence length in samples, latched at accept
//   pdout_ack    in   one-cycle pulse per frame: sample captured downstream
//   pdout_l      out  left sample {sum, 16'h0000}
//   pdout_r      out  right sample, identical to pdout_l
//   busy         out  high while playing tone or gap
//   abort        in   (DTMF_TONE_GEN_ABORT_EN only) cancel tone/gap
module dtmf_tone_gen (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        digit_valid,
  output logic        digit_ready,
  input  logic [3:0]  digit,
  input  logic [15:0] tone_samples,
  input  logic [15:0] gap_samples,
  input  logic        pdout_ack,
  output logic [31:0] pdout_l,
  output logic [31:0] pdout_r,
  output logic        busy
`ifdef DTMF_TONE_GEN_ABORT_EN
  ,
  input  logic        abort
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [15:0]        count, count_nxt;
  logic [3:0]         digit_q;
  logic [15:0]        gap_q;
  logic [23:0]        phase_row, phase_col;
  logic [23:0]        inc_row, inc_col;
  logic               accept;
  logic               abort_hit;

  logic               s1_v, s2_v;
  logic signed [15:0] s1_row, s1_col, s2_sum;

`ifdef DTMF_TONE_GEN_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // digit_ready is only ever high in IDLE, so accept implies IDLE.
  assign accept  = digit_valid && digit_ready;
  assign busy    = (state != IDLE);
  assign pdout_r = pdout_l;

  // Quarter-wave table: round(16383*sin(2*pi*j/256)), j = 0..64.
  function automatic logic [13:0] quarter(input logic [6:0] j);
    case (j)
      7'd0:  quarter = 14'd0;
      7'd1:  quarter = 14'd402;
      7'd2:  quarter = 14'd804;
      7'd3:  quarter = 14'd1205;
      7'd4:  quarter = 14'd1606;
      7'd5:  quarter = 14'd2005;
      7'd6:  quarter = 14'd2404;
      7'd7:  quarter = 14'd2801;
      7'd8:  quarter = 14'd3196;
      7'd9:  quarter = 14'd3590;
      7'd10: quarter = 14'd3981;
      7'd11: quarter = 14'd4370;
      7'd12: quarter = 14'd4756;
      7'd13: quarter = 14'd5139;
      7'd14: quarter = 14'd5519;
      7'd15: quarter = 14'd5896;
      7'd16: quarter = 14'd6270;
      7'd17: quarter = 14'd6639;
      7'd18: quarter = 14'd7005;
      7'd19: quarter = 14'd7366;
      7'd20: quarter = 14'd7723;
      7'd21: quarter = 14'd8075;
      7'd22: quarter = 14'd8423;
      7'd23: quarter = 14'd8765;
      7'd24: quarter = 14'd9102;
      7'd25: quarter = 14'd9433;
      7'd26: quarter = 14'd9759;
      7'd27: quarter = 14'd10079;
      7'd28: quarter = 14'd10393;
      7'd29: quarter = 14'd10701;
      7'd30: quarter = 14'd11002;
      7'd31: quarter = 14'd11297;
      7'd32: quarter = 14'd11585;
      7'd33: quarter = 14'd11865;
      7'd34: quarter = 14'd12139;
      7'd35: quarter = 14'd12405;
      7'd36: quarter = 14'd12664;
      7'd37: quarter = 14'd12915;
      7'd38: quarter = 14'd13159;
      7'd39: quarter = 14'd13394;
      7'd40: quarter = 14'd13622;
      7'd41: quarter = 14'd13841;
      7'd42: quarter = 14'd14052;
      7'd43: quarter = 14'd14255;
      7'd44: quarter = 14'd14449;
      7'd45: quarter = 14'd14634;
      7'd46: quarter = 14'd14810;
      7'd47: quarter = 14'd14977;
      7'd48: quarter = 14'd15136;
      7'd49: quarter = 14'd15285;
      7'd50: quarter = 14'd15425;
      7'd51: quarter = 14'd15556;
      7'd52: quarter = 14'd15678;
      7'd53: quarter = 14'd15790;
      7'd54: quarter = 14'd15892;
      7'd55: quarter = 14'd15985;
      7'd56: quarter = 14'd16068;
      7'd57: quarter = 14'd16142;
      7'd58: quarter = 14'd16206;
      7'd59: quarter = 14'd16260;
      7'd60: quarter = 14'd16304;
      7'd61: quarter = 14'd16339;
      7'd62: quarter = 14'd16363;
      7'd63: quarter = 14'd16378;
      default: quarter = 14'd16383;
    endcase
  endfunction

  // Full-wave sine from the quarter table: odd quadrants mirror the index,
  // upper half-wave negates.
  function automatic logic signed [15:0] sine(input logic [7:0] idx);
    logic [6:0]  j;
    logic [15:0] mag;
    j   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    mag = {2'b00, quarter(j)};
    sine = idx[7] ? -$signed(mag) : $signed(mag);
  endfunction

  // Keypad row: {1,2,3,A} {4,5,6,B} {7,8,9,C} {*,0,#,D}
  always_comb begin
    inc_row = 24'd1973420;
    case (digit_q)
      4'd1, 4'd2, 4'd3, 4'd12: inc_row = 24'd1461715;
      4'd4, 4'd5, 4'd6, 4'd13: inc_row = 24'd1614807;
      4'd7, 4'd8, 4'd9, 4'd14: inc_row = 24'd1786774;
      default:                 inc_row = 24'd1973420;
    endcase
  end

  // Keypad column: {1,4,7,*} {2,5,8,0} {3,6,9,#} {A,B,C,D}
  always_comb begin
    inc_col = 24'd3424649;
    case (digit_q)
      4'd1, 4'd4, 4'd7, 4'd10: inc_col = 24'd2535457;
      4'd2, 4'd5, 4'd8, 4'd0:  inc_col = 24'd2801795;
      4'd3, 4'd6, 4'd9, 4'd11: inc_col = 24'd3097494;
      default:                 inc_col = 24'd3424649;
    endcase
  end

  // Acks are ignored in IDLE, so an ack coinciding with accept has no effect.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (accept) begin
          if (tone_samples != '0) begin
            state_nxt = TONE;
            count_nxt = tone_samples;
          end else if (gap_samples != '0) begin
            state_nxt = GAP;
            count_nxt = gap_samples;
          end
        end
      end
      TONE: begin
        if (pdout_ack) begin
          if (count == 16'd1) begin
            if (gap_q != '0) begin
              state_nxt = GAP;
              count_nxt = gap_q;
            end else begin
              state_nxt = IDLE;
              count_nxt = '0;
            end
          end else begin
            count_nxt = count - 16'd1;
          end
        end
      end
      GAP: begin
        if (pdout_ack) begin
          if (count == 16'd1) begin
            state_nxt = IDLE;
            count_nxt = '0;
          end else begin
            count_nxt = count - 16'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
    if (abort_hit) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      digit_q     <= '0;
      gap_q       <= '0;
      phase_row   <= '0;
      phase_col   <= '0;
      digit_ready <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      // Rises one cycle after IDLE is entered; drops on the accept edge.
      digit_ready <= (state == IDLE) && (state_nxt == IDLE);
      if (accept) begin
        digit_q   <= digit;
        gap_q     <= gap_samples;
        phase_row <= '0;
        phase_col <= '0;
      end else if ((state == TONE) && pdout_ack && !abort_hit) begin
        phase_row <= phase_row + inc_row;
        phase_col <= phase_col + inc_col;
      end
    end
  end

  // Three-stage output pipeline: table lookup, sum, output register.
  // The valid flag follows the TONE state so leaving TONE zeroes pdout
  // three cycles later; abort flushes the whole pipe at once.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_row  <= '0;
      s1_col  <= '0;
      s2_v    <= 1'b0;
      s2_sum  <= '0;
      pdout_l <= '0;
    end else if (abort_hit) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      pdout_l <= '0;
    end else begin
      s1_v    <= (state == TONE);
      s1_row  <= sine(phase_row[23:16]);
      s1_col  <= sine(phase_col[23:16]);
      s2_v    <= s1_v;
      s2_sum  <= s1_row + s1_col;
      pdout_l <= s2_v ? {s2_sum, 16'h0000} : '0;
    end
  end

endmodule

// File: tb/tb_dtmf_tone_gen.sv
`timescale 1ns/1ps
module tb_dtmf_tone_gen;

  localparam real PI = 3.14159265358979323846;

  logic        mclk         = 1'b0;
  logic        rst_n        = 1'b1;
  logic        digit_valid  = 1'b0;
  logic        digit_ready;
  logic [3:0]  digit        = '0;
  logic [15:0] tone_samples = '0;
  logic [15:0] gap_samples  = '0;
  logic        pdout_ack    = 1'b0;
  logic [31:0] pdout_l, pdout_r;
  logic        busy;
`ifdef DTMF_TONE_GEN_ABORT_EN
  logic        abort        = 1'b0;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  real row_hz [4] = '{697.0, 770.0, 852.0, 941.0};
  real col_hz [4] = '{1209.0, 1336.0, 1477.0, 1633.0};
  int  cap [$];

  always #5 mclk = ~mclk;

  dtmf_tone_gen dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit       (digit),
    .tone_samples(tone_samples),
    .gap_samples (gap_samples),
    .pdout_ack   (pdout_ack),
    .pdout_l     (pdout_l),
    .pdout_r     (pdout_r),
    .busy        (busy)
`ifdef DTMF_TONE_GEN_ABORT_EN
    ,
    .abort       (abort)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic byte key_char(input int d);
    if (d < 10)  return byte'(48 + d);
    if (d == 10) return byte'(42);
    if (d == 11) return byte'(35);
    return byte'(65 + d - 12);
  endfunction

  // Position on the 4x4 keypad, row-major.
  function automatic int key_pos(input int d);
    string pad;
    pad = "123A456B789C*0#D";
    for (int i = 0; i < 16; i++)
      if (pad[i] == key_char(d)) return i;
    return 0;
  endfunction

  function automatic longint tone_inc(input real hz);
    return longint'(rnd(hz * 16777216.0 / 8000.0));
  endfunction

  function automatic int ref_sine(input longint phase);
    return rnd(16383.0 * $sin(2.0 * PI * real'(phase >> 16) / 256.0));
  endfunction

  function automatic int ref_sample(input int d, input int k);
    int     pos;
    longint pr, pc;
    pos = key_pos(d);
    pr  = (longint'(k) * tone_inc(row_hz[pos / 4])) % longint'(16777216);
    pc  = (longint'(k) * tone_inc(col_hz[pos % 4])) % longint'(16777216);
    return ref_sine(pr) + ref_sine(pc);
  endfunction

  function automatic logic [31:0] word_of(input int s);
    logic [15:0] h;
    h = s[15:0];
    return {h, 16'h0000};
  endfunction

  function automatic real power_at(input real hz);
    real re, im;
    re = 0.0;
    im = 0.0;
    foreach (cap[n]) begin
      re += real'(cap[n]) * $cos(2.0 * PI * hz * real'(n) / 8000.0);
      im += real'(cap[n]) * $sin(2.0 * PI * hz * real'(n) / 8000.0);
    end
    return re * re + im * im;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_pdout(input string tag, input int s);
    check({tag, " l"}, pdout_l, word_of(s));
    check({tag, " r"}, pdout_r, word_of(s));
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_digit(input int d, input int t, input int g, input bit hold);
    int waited;
    waited = 0;
    while (digit_ready !== 1'b1 && waited < 200) begin
      @(negedge mclk);
      waited++;
    end
    check("ready before accept", digit_ready, 1'b1);
    digit        = 4'(d);
    tone_samples = 16'(t);
    gap_samples  = 16'(g);
    digit_valid  = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    if (!hold) digit_valid = 1'b0;
  endtask

  // Issues acks; after each, checks the old sample still shows 2 cycles
  // later and the next one (or silence) 3 cycles later.
  task automatic run_acks(input int d, input int t, input int g, input int spacing,
                          input bit final_chk, input bit cap_on, input int stop_after);
    int prev, nxt;
    prev = 0;
    for (int a = 1; a <= t + g && a <= stop_after; a++) begin
      nxt = (a < t) ? ref_sample(d, a) : 0;
      pdout_ack = 1'b1;
      @(posedge mclk);
      @(negedge mclk);
      pdout_ack = 1'b0;
      @(negedge mclk);
      @(negedge mclk);
      check_pdout($sformatf("hold d%0d a%0d", d, a), prev);
      @(negedge mclk);
      check_pdout($sformatf("smp d%0d a%0d", d, a), nxt);
      if (cap_on && a < t) cap.push_back(int'($signed(pdout_l[31:16])));
      if (final_chk || a < t + g) begin
        check($sformatf("busy d%0d a%0d", d, a), busy, (a < t + g));
        check($sformatf("ready d%0d a%0d", d, a), digit_ready, (a == t + g));
      end
      prev = nxt;
      repeat (spacing - 4) @(negedge mclk);
    end
  endtask

  task automatic play(input int d, input int t, input int g, input int spacing, input bit cap_on);
    start_digit(d, t, g, 1'b0);
    repeat (3) @(negedge mclk);
    check_pdout($sformatf("smp0 d%0d", d), (t != 0) ? ref_sample(d, 0) : 0);
    check($sformatf("busy0 d%0d", d), busy, (t + g != 0));
    if (cap_on) cap.push_back(int'($signed(pdout_l[31:16])));
    run_acks(d, t, g, spacing, 1'b1, cap_on, t + g);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int  best_r, best_c, pos, maxabs;
    real p, pbest;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst pdout_l", pdout_l, 32'h0);
    check("rst pdout_r", pdout_r, 32'h0);
    check("rst busy", busy, 1'b0);
    check("rst ready", digit_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge mclk);
    check("ready after rst", digit_ready, 1'b1);

    // Digit 1, 4 tone samples, 2 gap samples, frame-rate acks
    play(1, 4, 2, 1536, 1'b0);

    // '*' for 800 samples: spectral peaks at 941 Hz and 1209 Hz
    cap.delete();
    play(10, 800, 0, 8, 1'b1);
    pos = key_pos(10);
    best_r = 0; pbest = -1.0;
    for (int i = 0; i < 4; i++) begin
      p = power_at(row_hz[i]);
      if (p > pbest) begin pbest = p; best_r = i; end
    end
    best_c = 0; pbest = -1.0;
    for (int i = 0; i < 4; i++) begin
      p = power_at(col_hz[i]);
      if (p > pbest) begin pbest = p; best_c = i; end
    end
    check("spectrum row peak", best_r, pos / 4);
    check("spectrum col peak", best_c, pos % 4);
    maxabs = 0;
    foreach (cap[n]) if ((cap[n] < 0 ? -cap[n] : cap[n]) > maxabs) maxabs = (cap[n] < 0 ? -cap[n] : cap[n]);
    check("sum within range", (maxabs <= 32766), 1'b1);

    // Zero tone and zero gap: nothing happens, an idle ack is ignored
    start_digit(4, 0, 0, 1'b0);
    pdout_ack = 1'b1;
    @(negedge mclk);
    pdout_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("zero busy", busy, 1'b0);
      check("zero ready", digit_ready, 1'b1);
      check_pdout("zero pdout", 0);
      @(negedge mclk);
    end

    // digit_valid held while busy with a different digit queued
    start_digit(5, 3, 1, 1'b1);
    digit        = 4'd9;
    tone_samples = 16'd3;
    gap_samples  = 16'd1;
    repeat (3) @(negedge mclk);
    check_pdout("held smp0", ref_sample(5, 0));
    run_acks(5, 3, 1, 6, 1'b0, 1'b0, 4);
    check("held second busy", busy, 1'b1);
    check("held second ready", digit_ready, 1'b0);
    digit_valid = 1'b0;
    check_pdout("held second smp0", ref_sample(9, 0));
    run_acks(9, 3, 1, 6, 1'b1, 1'b0, 4);

    // Reset pulse mid-tone
    start_digit(8, 6, 2, 1'b0);
    repeat (3) @(negedge mclk);
    run_acks(8, 6, 2, 6, 1'b1, 1'b0, 2);
    #3 rst_n = 1'b0;
    #1;
    check_pdout("midrst pdout", 0);
    check("midrst busy", busy, 1'b0);
    check("midrst ready", digit_ready, 1'b0);
    @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
    check("midrst ready after", digit_ready, 1'b1);
    play(int'($urandom_range(15, 0)), 3, 1, 5, 1'b0);

`ifdef DTMF_TONE_GEN_ABORT_EN
    // Abort together with an ack in TONE
    start_digit(7, 5, 2, 1'b0);
    repeat (3) @(negedge mclk);
    run_acks(7, 5, 2, 6, 1'b1, 1'b0, 2);
    abort     = 1'b1;
    pdout_ack = 1'b1;
    @(posedge mclk);
    #1;
    check("abort busy", busy, 1'b0);
    check_pdout("abort pdout", 0);
    @(negedge mclk);
    abort     = 1'b0;
    pdout_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      check_pdout("abort quiet", 0);
      check("abort quiet busy", busy, 1'b0);
    end
    check("abort ready", digit_ready, 1'b1);
`endif

    // Randomized digits and lengths
    for (int n = 0; n < 8; n++) begin
      play(int'($urandom_range(15, 0)), int'($urandom_range(6, 0)),
           int'($urandom_range(3, 0)), int'($urandom_range(12, 4)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
